// File: rtl/fft_layer_sequencer.sv
// Run controller for the in-place FFT: walks the scramble layer and each butterfly
// layer in turn, chip-selects the active one and routes its memory signals onto the shared bus.
module fft_layer_sequencer #(
  parameter int FFT_SIZE       = 8,
  parameter int NUM_LAYERS     = $clog2(FFT_SIZE) + 1,
  parameter int ADDR_SIZE      = $clog2(2 * FFT_SIZE),
  parameter int TWID_ADDR_SIZE = 7,
  parameter int PIPE_LATENCY   = 2,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic                                 i_CLK,
  input  logic                                 i_RST,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [NUM_LAYERS-1:0]                i_layer_done,
  input  logic [NUM_LAYERS-1:0]                i_rden_vec,
  input  logic [NUM_LAYERS-1:0]                i_wren_vec,
  input  logic [NUM_LAYERS*ADDR_SIZE-1:0]      i_rdaddr_A_vec,
  input  logic [NUM_LAYERS*ADDR_SIZE-1:0]      i_rdaddr_B_vec,
  input  logic [NUM_LAYERS*TWID_ADDR_SIZE-1:0] i_rdaddr_tw_vec,
  output logic [NUM_LAYERS-1:0]                o_cs,
  output logic [$clog2(NUM_LAYERS)-1:0]        o_layer_sel,
  output logic                                 o_bus_rden,
  output logic                                 o_bus_wren,
  output logic [ADDR_SIZE-1:0]                 o_bus_rdaddr_A,
  output logic [ADDR_SIZE-1:0]                 o_bus_rdaddr_B,
  output logic [TWID_ADDR_SIZE-1:0]            o_bus_twaddr,
  output logic                                 o_wrsel,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [TIMER_WIDTH-1:0]               o_cycles
);

  localparam int LSEL_W = $clog2(NUM_LAYERS);
  localparam int DRN_W  = (PIPE_LATENCY < 1) ? 1 : $clog2(PIPE_LATENCY + 1);
  localparam logic [LSEL_W-1:0] LAST_LAYER = LSEL_W'(NUM_LAYERS - 1);
  localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(PIPE_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [LSEL_W-1:0]      r_layer_sel;
  logic [LSEL_W-1:0]      w_next_layer;
  logic [DRN_W-1:0]       r_drain_cnt;
  logic [DRN_W-1:0]       w_next_drain;
  logic [TIMER_WIDTH-1:0] r_cycles;

  logic                      w_sel_done;
  logic                      w_sel_rden;
  logic                      w_sel_wren;
  logic [ADDR_SIZE-1:0]      w_sel_addr_A;
  logic [ADDR_SIZE-1:0]      w_sel_addr_B;
  logic [TWID_ADDR_SIZE-1:0] w_sel_tw;
  logic                      w_last_layer;
  logic                      w_accept_start;

  assign w_last_layer   = (r_layer_sel == LAST_LAYER);
  assign w_accept_start = (r_state == S_IDLE) && i_start && !i_abort;

  // Pick out the active layer's slice; the scramble layer has no twiddle address.
  always_comb begin
    w_sel_done   = 1'b0;
    w_sel_rden   = 1'b0;
    w_sel_wren   = 1'b0;
    w_sel_addr_A = '0;
    w_sel_addr_B = '0;
    w_sel_tw     = '0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
      if (r_layer_sel == LSEL_W'(n)) begin
        w_sel_done   = i_layer_done[n];
        w_sel_rden   = i_rden_vec[n];
        w_sel_wren   = i_wren_vec[n];
        w_sel_addr_A = i_rdaddr_A_vec[n*ADDR_SIZE +: ADDR_SIZE];
        w_sel_addr_B = i_rdaddr_B_vec[n*ADDR_SIZE +: ADDR_SIZE];
        if (n != 0) begin
          w_sel_tw = i_rdaddr_tw_vec[n*TWID_ADDR_SIZE +: TWID_ADDR_SIZE];
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_layer = r_layer_sel;
    w_next_drain = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept_start) begin
          w_next_state = S_RUN;
          w_next_layer = '0;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
          w_next_layer = '0;
        end else if (w_sel_done) begin
          if (r_layer_sel == '0) begin
            w_next_layer = r_layer_sel + 1'b1;
          end else if (PIPE_LATENCY > 0) begin
            w_next_state = S_DRAIN;
            w_next_drain = DRAIN_INIT;
          end else if (w_last_layer) begin
            w_next_state = S_DONE;
            w_next_layer = '0;
          end else begin
            w_next_layer = r_layer_sel + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
          w_next_layer = '0;
        end else if (r_drain_cnt <= DRN_W'(1)) begin
          if (w_last_layer) begin
            w_next_state = S_DONE;
            w_next_layer = '0;
          end else begin
            w_next_state = S_RUN;
            w_next_layer = r_layer_sel + 1'b1;
          end
        end else begin
          w_next_drain = r_drain_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_layer = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_layer = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Cycle counter is cleared by an accepted start and frozen by abort or saturation.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_layer_sel <= '0;
      r_drain_cnt <= '0;
      r_cycles    <= '0;
    end else begin
      r_layer_sel <= w_next_layer;
      r_drain_cnt <= w_next_drain;
      if (w_accept_start) begin
        r_cycles <= '0;
      end else if ((r_state == S_RUN || r_state == S_DRAIN) && !i_abort &&
                   (r_cycles != '1)) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  // During drain the pipe still writes back, so only the write side stays live.
  always_comb begin
    o_cs           = '0;
    o_bus_rden     = 1'b0;
    o_bus_wren     = 1'b0;
    o_bus_rdaddr_A = '0;
    o_bus_rdaddr_B = '0;
    o_bus_twaddr   = '0;
    o_wrsel        = 1'b0;
    case (r_state)
      S_RUN: begin
        o_cs           = NUM_LAYERS'(1) << r_layer_sel;
        o_bus_rden     = w_sel_rden;
        o_bus_wren     = w_sel_wren;
        o_bus_rdaddr_A = w_sel_addr_A;
        o_bus_rdaddr_B = w_sel_addr_B;
        o_bus_twaddr   = w_sel_tw;
        o_wrsel        = (r_layer_sel != '0);
      end
      S_DRAIN: begin
        o_bus_wren     = 1'b1;
        o_bus_rdaddr_A = w_sel_addr_A;
        o_bus_rdaddr_B = w_sel_addr_B;
        o_bus_twaddr   = w_sel_tw;
        o_wrsel        = 1'b1;
      end
      default: begin
        o_cs = '0;
      end
    endcase
  end

  assign o_layer_sel = r_layer_sel;
  assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_cycles    = r_cycles;

endmodule

// File: tb/tb_fft_layer_sequencer.sv
// Directed bench for fft_layer_sequencer: an 8-point/drain-2 instance and a
// 16-point/no-drain instance, each driven by a stub that finishes a layer 4 cycles after its chip-select.
module tb_fft_layer_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int vectorCount = 0;
   int failCount = 0;

   // 8-point instance
   logic        startA = 1'b0;
   logic        abortA = 1'b0;
   logic [3:0]  doneStubA = '0;
   logic [3:0]  spuriousA = '0;
   logic [3:0]  layerDoneA;
   logic [3:0]  rdenVecA = 4'b1111;
   logic [3:0]  wrenVecA = 4'b1010;
   logic [15:0] addrAVecA = {4'd4, 4'd3, 4'd2, 4'd1};
   logic [15:0] addrBVecA = {4'd11, 4'd10, 4'd9, 4'd8};
   logic [27:0] twVecA = {7'd51, 7'd35, 7'd19, 7'd3};
   logic [3:0]  csA;
   logic [1:0]  layerSelA;
   logic        rdenA, wrenA, wrselA, busyA, doneA;
   logic [3:0]  busAddrAA, busAddrBA;
   logic [6:0]  busTwA;
   logic [15:0] cyclesA;

   // 16-point instance
   logic        startB = 1'b0;
   logic        abortB = 1'b0;
   logic [4:0]  doneStubB = '0;
   logic [4:0]  rdenVecB = '0;
   logic [4:0]  wrenVecB = '0;
   logic [24:0] addrAVecB = '0;
   logic [24:0] addrBVecB = '0;
   logic [34:0] twVecB = '0;
   logic [4:0]  csB;
   logic [2:0]  layerSelB;
   logic        rdenB, wrenB, wrselB, busyB, doneB;
   logic [4:0]  busAddrAB, busAddrBB;
   logic [6:0]  busTwB;
   logic [15:0] cyclesB;

   assign layerDoneA = doneStubA | spuriousA;

   fft_layer_sequencer #(.FFT_SIZE(8), .PIPE_LATENCY(2)) dutA (
      .i_CLK(clk), .i_RST(rst), .i_start(startA), .i_abort(abortA),
      .i_layer_done(layerDoneA), .i_rden_vec(rdenVecA), .i_wren_vec(wrenVecA),
      .i_rdaddr_A_vec(addrAVecA), .i_rdaddr_B_vec(addrBVecA), .i_rdaddr_tw_vec(twVecA),
      .o_cs(csA), .o_layer_sel(layerSelA), .o_bus_rden(rdenA), .o_bus_wren(wrenA),
      .o_bus_rdaddr_A(busAddrAA), .o_bus_rdaddr_B(busAddrBA), .o_bus_twaddr(busTwA),
      .o_wrsel(wrselA), .o_busy(busyA), .o_done(doneA), .o_cycles(cyclesA)
   );

   fft_layer_sequencer #(.FFT_SIZE(16), .PIPE_LATENCY(0)) dutB (
      .i_CLK(clk), .i_RST(rst), .i_start(startB), .i_abort(abortB),
      .i_layer_done(doneStubB), .i_rden_vec(rdenVecB), .i_wren_vec(wrenVecB),
      .i_rdaddr_A_vec(addrAVecB), .i_rdaddr_B_vec(addrBVecB), .i_rdaddr_tw_vec(twVecB),
      .o_cs(csB), .o_layer_sel(layerSelB), .o_bus_rden(rdenB), .o_bus_wren(wrenB),
      .o_bus_rdaddr_A(busAddrAB), .o_bus_rdaddr_B(busAddrBB), .o_bus_twaddr(busTwB),
      .o_wrsel(wrselB), .o_busy(busyB), .o_done(doneB), .o_cycles(cyclesB)
   );

   always #5 clk = ~clk;

   // Layer stubs: count negedges since the chip-select last changed and raise
   // the selected layer's done during the fourth cycle it is selected.
   int stubCntA = 0;
   logic [3:0] prevCsA = '0;
   always @(negedge clk) begin
      if (csA != prevCsA) stubCntA = (csA != '0) ? 1 : 0;
      else if (csA != '0) stubCntA = stubCntA + 1;
      prevCsA = csA;
      doneStubA = (stubCntA == 4) ? csA : '0;
   end

   int stubCntB = 0;
   logic [4:0] prevCsB = '0;
   always @(negedge clk) begin
      if (csB != prevCsB) stubCntB = (csB != '0) ? 1 : 0;
      else if (csB != '0) stubCntB = stubCntB + 1;
      prevCsB = csB;
      doneStubB = (stubCntB == 4) ? csB : '0;
   end

   // Single comparison point: counts every vector and reports any mismatch.
   task automatic checkOutput(input string tag, input int unsigned observed,
                              input int unsigned expected);
      vectorCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sA, input logic aA, input logic sB);
      startA = sA;
      abortA = aA;
      startB = sB;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hand-derived chip-select timeline of a full 8-point run (t = cycles after start edge).
   function automatic int unsigned expCsRun1(input int t);
      if (t < 4) return 1;
      if (t < 8) return 2;
      if (t < 10) return 0;
      if (t < 14) return 4;
      if (t < 16) return 0;
      if (t < 20) return 8;
      return 0;
   endfunction

   function automatic int unsigned expLayerRun1(input int t);
      if (t < 4) return 0;
      if (t < 10) return 1;
      if (t < 16) return 2;
      if (t < 22) return 3;
      return 0;
   endfunction

   initial begin
      // Asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #2;
      checkOutput("reset cs", 32'(csA), 0);
      checkOutput("reset busy", 32'(busyA), 0);
      checkOutput("reset done", 32'(doneA), 0);
      checkOutput("reset cycles", 32'(cyclesA), 0);
      checkOutput("reset layer_sel", 32'(layerSelA), 0);
      checkOutput("reset rden", 32'(rdenA), 0);
      checkOutput("reset wren", 32'(wrenA), 0);
      #4 rst = 1'b0;
      step(2);

      $display("[TB] full 8-point run");
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int t = 0; t <= 23; t++) begin
         checkOutput($sformatf("run1 cs t%0d", t), 32'(csA), expCsRun1(t));
         checkOutput($sformatf("run1 layer_sel t%0d", t), 32'(layerSelA), expLayerRun1(t));
         checkOutput($sformatf("run1 done t%0d", t), 32'(doneA), (t == 22) ? 1 : 0);
         checkOutput($sformatf("run1 busy t%0d", t), 32'(busyA), (t < 22) ? 1 : 0);
         checkOutput($sformatf("run1 cycles t%0d", t), 32'(cyclesA), (t <= 22) ? t : 22);
         if (t == 0) begin
            checkOutput("L0 addrA", 32'(busAddrAA), 1);
            checkOutput("L0 addrB", 32'(busAddrBA), 8);
            checkOutput("L0 twaddr", 32'(busTwA), 0);
            checkOutput("L0 rden", 32'(rdenA), 1);
            checkOutput("L0 wren", 32'(wrenA), 0);
            checkOutput("L0 wrsel", 32'(wrselA), 0);
         end
         if (t == 4) begin
            checkOutput("L1 addrA", 32'(busAddrAA), 2);
            checkOutput("L1 addrB", 32'(busAddrBA), 9);
            checkOutput("L1 twaddr", 32'(busTwA), 19);
            checkOutput("L1 wren", 32'(wrenA), 1);
            checkOutput("L1 wrsel", 32'(wrselA), 1);
         end
         if (t == 8) begin
            checkOutput("drain rden", 32'(rdenA), 0);
            checkOutput("drain wren", 32'(wrenA), 1);
            checkOutput("drain wrsel", 32'(wrselA), 1);
         end
         if (t == 10) begin
            checkOutput("L2 addrA", 32'(busAddrAA), 3);
            checkOutput("L2 twaddr", 32'(busTwA), 35);
            checkOutput("L2 wren", 32'(wrenA), 0);
            checkOutput("L2 wrsel", 32'(wrselA), 1);
         end
         if (t == 23) begin
            checkOutput("idle rden", 32'(rdenA), 0);
            checkOutput("idle wren", 32'(wrenA), 0);
            checkOutput("idle wrsel", 32'(wrselA), 0);
         end
         step(1);
      end

      $display("[TB] start while busy, spurious done, abort in drain");
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("busy start layer_sel", 32'(layerSelA), 0);
      checkOutput("busy start cycles", 32'(cyclesA), 3);
      checkOutput("busy start cs", 32'(csA), 1);
      step(1);
      checkOutput("t4 layer_sel", 32'(layerSelA), 1);
      spuriousA = 4'b1000;
      for (int i = 5; i <= 7; i++) begin
         step(1);
         checkOutput($sformatf("spurious layer_sel t%0d", i), 32'(layerSelA), 1);
         checkOutput($sformatf("spurious cs t%0d", i), 32'(csA), 2);
      end
      spuriousA = '0;
      step(7);
      checkOutput("pre-abort layer_sel", 32'(layerSelA), 2);
      checkOutput("pre-abort cs", 32'(csA), 0);
      checkOutput("pre-abort busy", 32'(busyA), 1);
      checkOutput("pre-abort cycles", 32'(cyclesA), 14);
      applyStimulus(1'b0, 1'b1, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort busy", 32'(busyA), 0);
      checkOutput("abort cs", 32'(csA), 0);
      checkOutput("abort cycles", 32'(cyclesA), 14);
      checkOutput("abort done", 32'(doneA), 0);
      for (int i = 0; i < 4; i++) begin
         step(1);
         checkOutput($sformatf("post-abort done %0d", i), 32'(doneA), 0);
         checkOutput($sformatf("post-abort cycles %0d", i), 32'(cyclesA), 14);
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("start+abort busy", 32'(busyA), 0);
      checkOutput("start+abort cs", 32'(csA), 0);
      checkOutput("start+abort cycles", 32'(cyclesA), 14);
      step(1);
      checkOutput("start+abort busy later", 32'(busyA), 0);

      $display("[TB] asynchronous reset mid-run");
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(5);
      checkOutput("mid-run cycles", 32'(cyclesA), 5);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset cs", 32'(csA), 0);
      checkOutput("async reset busy", 32'(busyA), 0);
      checkOutput("async reset cycles", 32'(cyclesA), 0);
      checkOutput("async reset layer_sel", 32'(layerSelA), 0);
      rst = 1'b0;
      step(1);
      checkOutput("after reset busy", 32'(busyA), 0);

      $display("[TB] 16-point run without drain");
      applyStimulus(1'b0, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int t = 0; t <= 21; t++) begin
         checkOutput($sformatf("run16 cs t%0d", t), 32'(csB), (t < 20) ? (32'd1 << (t / 4)) : 0);
         checkOutput($sformatf("run16 done t%0d", t), 32'(doneB), (t == 20) ? 1 : 0);
         checkOutput($sformatf("run16 busy t%0d", t), 32'(busyB), (t < 20) ? 1 : 0);
         checkOutput($sformatf("run16 cycles t%0d", t), 32'(cyclesB), (t <= 20) ? t : 20);
         if (t == 16) checkOutput("run16 last layer_sel", 32'(layerSelB), 4);
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
